// File: rtl/des_core_iter.sv
// Iterative DES block cipher core. A block is loaded on the accepting edge,
// ROUNDS_PER_CYCLE Feistel rounds are applied per clock in RUN, and the
// result is held in DONE until the consumer takes it.
//
// state | meaning
// IDLE  | waiting for a block; in_ready high
// RUN   | applying rounds; round counter advances by ROUNDS_PER_CYCLE
// DONE  | result held on out_data; out_valid high until out_ready
module des_core_iter #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [63:0] in_key,
    input  logic        in_decrypt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data
);

    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4 &&
        ROUNDS_PER_CYCLE != 8 && ROUNDS_PER_CYCLE != 16) begin : g_bad_rounds
        $error("des_core_iter: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    localparam logic [4:0] STEP     = 5'(ROUNDS_PER_CYCLE);
    localparam logic [4:0] LAST_CNT = 5'(16 - ROUNDS_PER_CYCLE);

    // Permutation tables use DES 1-based bit numbers (bit 1 = MSB).
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9,  1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41, 9,  49, 17, 57, 25};
    localparam int E_T [48] = '{
        32, 1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
        8,  9,  10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32, 1};
    localparam int P_T [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1,  15, 23, 26, 5,  18, 31, 10,
        2,  8, 24, 14, 32, 27, 3,  9,  19, 13, 30, 6,  22, 11, 4,  25};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17, 9,   1,  58, 50, 42, 34, 26, 18,
        10, 2,  59, 51, 43, 35, 27,  19, 11, 3,  60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7,  62, 54, 46, 38, 30, 22,
        14, 6,  61, 53, 45, 37, 29,  21, 13, 5,  28, 20, 12, 4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24, 1,  5,   3,  28, 15, 6,  21, 10,
        23, 19, 12, 4,  26, 8,   16, 7,  27, 20, 13, 2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};
    // S1..S8, each 4 rows of 16, indexed box*64 + row*16 + col.
    localparam int SBOX_T [512] = '{
        14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,   0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,   15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
        15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,   3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,   13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
        10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,   13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,   1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
        7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,   13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,   3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
        2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,   14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,   11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
        12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,   10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,   4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
        4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,   13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,   6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
        13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,   1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,   2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] l_q, r_q, l_v, r_v;
    logic [27:0] c_q, d_q, c_v, d_v;
    logic [4:0]  cnt_q, rnd_v;
    logic [47:0] sub_v;
    logic [31:0] f_v;
    logic        dec_q;
    logic        last_step;

    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63 - i] = x[6'(64 - IP_T[i])];
        return y;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63 - i] = x[6'(64 - FP_T[i])];
        return y;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int i = 0; i < 56; i++) y[55 - i] = x[6'(64 - PC1_T[i])];
        return y;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[47 - i] = x[6'(56 - PC2_T[i])];
        return y;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] y;
        logic [5:0]  b;
        logic [8:0]  sidx;
        x = '0;
        for (int i = 0; i < 48; i++) x[47 - i] = r[5'(32 - E_T[i])];
        x = x ^ k;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            b = x[47 - 6 * i -: 6];
            // row is the outer bit pair, column the middle four bits
            sidx = 9'(i * 64) + 9'({b[5], b[0], b[4:1]});
            s[31 - 4 * i -: 4] = 4'(SBOX_T[sidx]);
        end
        y = '0;
        for (int i = 0; i < 32; i++) y[31 - i] = s[5'(32 - P_T[i])];
        return y;
    endfunction

    // Decrypt starts from C0/D0, which equals C16/D16, so round 1 needs no shift.
    function automatic logic [1:0] shift_amt(input logic [4:0] rnd, input logic dec);
        if (dec && rnd == 5'd1) return 2'd0;
        if (rnd == 5'd1 || rnd == 5'd2 || rnd == 5'd9 || rnd == 5'd16) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [27:0] rotate(input logic [27:0] x, input logic [1:0] amt,
                                           input logic dec);
        case (amt)
            2'd1:    return dec ? {x[0], x[27:1]} : {x[26:0], x[27]};
            2'd2:    return dec ? {x[1:0], x[27:2]} : {x[25:0], x[27:26]};
            default: return x;
        endcase
    endfunction

    assign last_step = (cnt_q == LAST_CNT);

    // State register.
    always_ff @(posedge clock) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (last_step) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Unrolled round chain: ROUNDS_PER_CYCLE key-schedule steps and Feistel rounds.
    always_comb begin
        l_v   = l_q;
        r_v   = r_q;
        c_v   = c_q;
        d_v   = d_q;
        rnd_v = '0;
        sub_v = '0;
        f_v   = '0;
        for (int k = 0; k < ROUNDS_PER_CYCLE; k++) begin
            rnd_v = cnt_q + 5'(k) + 5'd1;
            c_v   = rotate(c_v, shift_amt(rnd_v, dec_q), dec_q);
            d_v   = rotate(d_v, shift_amt(rnd_v, dec_q), dec_q);
            sub_v = perm_pc2({c_v, d_v});
            f_v   = l_v ^ feistel(r_v, sub_v);
            l_v   = r_v;
            r_v   = f_v;
        end
    end

    // Block load on accept, round iteration in RUN, result capture on the last round.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            l_q      <= '0;
            r_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
            cnt_q    <= '0;
            dec_q    <= 1'b0;
            out_data <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        {l_q, r_q} <= perm_ip(in_data);
                        {c_q, d_q} <= perm_pc1(in_key);
                        dec_q      <= in_decrypt;
                        cnt_q      <= '0;
                    end
                end
                RUN: begin
                    l_q   <= l_v;
                    r_q   <= r_v;
                    c_q   <= c_v;
                    d_q   <= d_v;
                    cnt_q <= cnt_q + STEP;
                    if (last_step) out_data <= perm_fp({r_v, l_v});
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_des_core_iter.sv
// Directed bench for des_core_iter: known-answer vectors, latency, backpressure,
// input churn, mid-run reset, and the other ROUNDS_PER_CYCLE settings.
module tb_des_core_iter;

    localparam int NP = 4;

    logic        clock = 1'b0;
    logic        resetn;
    logic        in_valid, in_ready, in_decrypt, out_valid, out_ready;
    logic [63:0] in_data, in_key, out_data;

    logic [NP-1:0] p_in_valid, p_in_ready, p_out_valid, p_out_ready;
    logic [63:0]   p_out_data [NP];

    int n_chk = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    des_core_iter u_dut (
        .clock     (clock),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .in_decrypt(in_decrypt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // Instances with 2, 4, 8 and 16 rounds per clock sharing the data inputs.
    for (genvar g = 0; g < NP; g++) begin : g_par
        des_core_iter #(.ROUNDS_PER_CYCLE(2 << g)) u_dut (
            .clock     (clock),
            .resetn    (resetn),
            .in_valid  (p_in_valid[g]),
            .in_ready  (p_in_ready[g]),
            .in_data   (in_data),
            .in_key    (in_key),
            .in_decrypt(in_decrypt),
            .out_valid (p_out_valid[g]),
            .out_ready (p_out_ready[g]),
            .out_data  (p_out_data[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Waits up to 40 cycles for out_valid; lat = 0 means it never came.
    task automatic wait_out(input bit churn, output int lat);
        lat = 0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            if (churn) begin
                in_data    = {$urandom, $urandom};
                in_key     = {$urandom, $urandom};
                in_decrypt = ~in_decrypt;
            end
            step();
            if (out_valid) lat = c;
        end
    endtask

    task automatic run_block(input string tag, input logic [63:0] data, input logic [63:0] key,
                             input logic dec, input logic [63:0] exp, input bit churn);
        int lat;
        chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
        in_valid   = 1'b1;
        in_data    = data;
        in_key     = key;
        in_decrypt = dec;
        step();
        if (!churn) in_valid = 1'b0;
        chk({tag, "_busy"}, 64'(in_ready), 64'd0);
        wait_out(churn, lat);
        in_valid = 1'b0;
        chk({tag, "_lat"}, 64'(lat), 64'd16);
        chk({tag, "_out"}, out_data, exp);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_vld0"}, 64'(out_valid), 64'd0);
        chk({tag, "_rdy1"}, 64'(in_ready), 64'd1);
        chk({tag, "_hold"}, out_data, exp);
    endtask

    task automatic par_block(input string tag, input logic [63:0] data, input logic [63:0] key,
                             input logic dec, input logic [63:0] exp);
        int lat [NP];
        for (int g = 0; g < NP; g++) begin
            chk($sformatf("%s_rdy%0d", tag, g), 64'(p_in_ready[g]), 64'd1);
            lat[g] = 0;
        end
        p_in_valid = '1;
        in_data    = data;
        in_key     = key;
        in_decrypt = dec;
        step();
        p_in_valid = '0;
        for (int c = 1; c <= 20; c++) begin
            step();
            for (int g = 0; g < NP; g++)
                if (p_out_valid[g] && lat[g] == 0) lat[g] = c;
        end
        for (int g = 0; g < NP; g++) begin
            chk($sformatf("%s_lat%0d", tag, g), 64'(lat[g]), 64'(8 >> g));
            chk($sformatf("%s_out%0d", tag, g), p_out_data[g], exp);
        end
        p_out_ready = '1;
        step();
        p_out_ready = '0;
        for (int g = 0; g < NP; g++)
            chk($sformatf("%s_vld0_%0d", tag, g), 64'(p_out_valid[g]), 64'd0);
    endtask

    initial begin
        int lat;
        resetn      = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        in_data     = '0;
        in_key      = '0;
        in_decrypt  = 1'b0;
        p_in_valid  = '0;
        p_out_ready = '0;

        step();
        step();
        chk("rst_vld", 64'(out_valid), 64'd0);
        chk("rst_data", out_data, 64'h0);
        resetn = 1'b1;
        step();
        chk("rst_rdy", 64'(in_ready), 64'd1);

        run_block("enc1", 64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0, 64'h85E813540F0AB405, 1'b0);
        run_block("dec1", 64'h85E813540F0AB405, 64'h133457799BBCDFF1, 1'b1, 64'h0123456789ABCDEF, 1'b0);
        run_block("enc2", 64'h8787878787878787, 64'h0E329232EA6D0D73, 1'b0, 64'h0000000000000000, 1'b0);

        // Backpressure: result held while a new block waits on in_valid.
        in_valid   = 1'b1;
        in_data    = 64'h0123456789ABCDEF;
        in_key     = 64'h133457799BBCDFF1;
        in_decrypt = 1'b0;
        step();
        in_valid = 1'b0;
        wait_out(1'b0, lat);
        chk("bp_lat", 64'(lat), 64'd16);
        in_valid   = 1'b1;
        in_data    = 64'h85E813540F0AB405;
        in_decrypt = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_data", out_data, 64'h85E813540F0AB405);
            chk("bp_vld", 64'(out_valid), 64'd1);
            chk("bp_rdy", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_idle_rdy", 64'(in_ready), 64'd1);
        chk("bp_idle_vld", 64'(out_valid), 64'd0);
        chk("bp_idle_data", out_data, 64'h85E813540F0AB405);
        step();
        in_valid = 1'b0;
        chk("bp_acc", 64'(in_ready), 64'd0);
        wait_out(1'b0, lat);
        chk("bp2_lat", 64'(lat), 64'd16);
        chk("bp2_out", out_data, 64'h0123456789ABCDEF);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        run_block("churn", 64'h0000000000000000, 64'h0E329232EA6D0D73, 1'b1, 64'h8787878787878787, 1'b1);

        par_block("penc", 64'h8787878787878787, 64'h0E329232EA6D0D73, 1'b0, 64'h0000000000000000);
        par_block("pdec", 64'h85E813540F0AB405, 64'h133457799BBCDFF1, 1'b1, 64'h0123456789ABCDEF);

        // Reset while round 7 is being computed.
        chk("mr_rdy", 64'(in_ready), 64'd1);
        in_valid   = 1'b1;
        in_data    = 64'h0123456789ABCDEF;
        in_key     = 64'h133457799BBCDFF1;
        in_decrypt = 1'b0;
        step();
        in_valid = 1'b0;
        repeat (6) step();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        chk("mr_vld", 64'(out_valid), 64'd0);
        chk("mr_data", out_data, 64'h0);
        chk("mr_rdy1", 64'(in_ready), 64'd1);
        repeat (20) step();
        chk("mr_vld_late", 64'(out_valid), 64'd0);
        run_block("mr_next", 64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0, 64'h85E813540F0AB405, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
